// File: rtl/memmap_pkg.sv
// Shared constants for the NGS memory-mapper register file: register offsets,
// page reset values and CTRL bit positions.
package memmap_pkg;

  localparam int NUM_PG   = 4;

  localparam int OFS_PG0  = 0;
  localparam int OFS_PG1  = 1;
  localparam int OFS_PG2  = 2;
  localparam int OFS_PG3  = 3;
  localparam int OFS_CTRL = 4;

  localparam logic [7:0] PG0_RST = 8'h00;
  localparam logic [7:0] PG1_RST = 8'h03;
  localparam logic [7:0] PG2_RST = 8'h00;
  localparam logic [7:0] PG3_RST = 8'h00;

  localparam int CTRL_NOROM = 0;
  localparam int CTRL_RAMRO = 1;

  function automatic logic [7:0] pg_rst_val(input int idx);
    logic [7:0] val;
    case (idx)
      OFS_PG0: val = PG0_RST;
      OFS_PG1: val = PG1_RST;
      OFS_PG2: val = PG2_RST;
      default: val = PG3_RST;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/z80_strobe_sync.sv
// Synchronizes one asynchronous Z80 strobe into clk and produces an arm-gated
// single-cycle rising-edge pulse plus an "all stages idle" indication.
module z80_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic arm,
  output logic level,
  output logic rise,
  output logic idle
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   level_d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg    <= '0;
      level_d_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], strobe};
      level_d_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = arm & level & ~level_d_reg;
  assign idle  = ~|sync_reg;

endmodule

// File: rtl/memmap_regs.sv
// Z80 I/O register file driving the NGS memory-mapper page/mode controls.
// Optional readback onto the Z80 data bus is enabled by defining MEMMAP_READBACK_EN.
module memmap_regs
  import memmap_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] PORT_BASE   = 8'h10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] a,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_en,
  output logic [7:0] mode_pg0,
  output logic [7:0] mode_pg1,
  output logic [7:0] mode_pg2,
  output logic [7:0] mode_pg3,
  output logic       mode_norom,
  output logic       mode_ramro,
  output logic       pg_upd
);

  logic wr_act, rd_act;
  logic wr_s, rd_s, wr_rise, rd_rise, wr_idle, rd_idle;
  logic started_reg, arm_reg;

  assign wr_act = ~iorq_n & ~wr_n & m1_n;
  assign rd_act = ~iorq_n & ~rd_n & m1_n;

  // Arming waits one clock after reset so the chain holds a real sample of the
  // strobe; a strobe held across reset release therefore never arms the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      started_reg <= 1'b0;
      arm_reg     <= 1'b0;
    end else begin
      started_reg <= 1'b1;
      if (started_reg && wr_idle && rd_idle)
        arm_reg <= 1'b1;
    end
  end

  z80_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rst(rst), .strobe(wr_act), .arm(arm_reg),
    .level(wr_s), .rise(wr_rise), .idle(wr_idle)
  );

  z80_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .rst(rst), .strobe(rd_act), .arm(arm_reg),
    .level(rd_s), .rise(rd_rise), .idle(rd_idle)
  );

  logic [7:0]              ofs;
  logic [NUM_PG-1:0]       pg_hit;
  logic                    ctrl_hit;
  logic                    changed;
  logic [NUM_PG-1:0][7:0]  pg_reg;
  logic                    norom_reg, ramro_reg, pg_upd_reg;

  assign ofs      = a - PORT_BASE;
  assign ctrl_hit = (ofs == 8'(OFS_CTRL));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PG; gi++) begin : g_pg_hit
      assign pg_hit[gi] = (ofs == 8'(gi));
    end
  endgenerate

  always_comb begin
    changed = 1'b0;
    for (int i = 0; i < NUM_PG; i++)
      if (pg_hit[i] && (din != pg_reg[i]))
        changed = 1'b1;
    if (ctrl_hit && ((din[CTRL_NOROM] != norom_reg) || (din[CTRL_RAMRO] != ramro_reg)))
      changed = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PG; i++)
        pg_reg[i] <= pg_rst_val(i);
      norom_reg  <= 1'b0;
      ramro_reg  <= 1'b0;
      pg_upd_reg <= 1'b0;
    end else begin
      pg_upd_reg <= wr_rise & changed;
      if (wr_rise) begin
        for (int i = 0; i < NUM_PG; i++)
          if (pg_hit[i])
            pg_reg[i] <= din;
        if (ctrl_hit) begin
          norom_reg <= din[CTRL_NOROM];
          ramro_reg <= din[CTRL_RAMRO];
        end
      end
    end
  end

  assign mode_pg0   = pg_reg[2'(OFS_PG0)];
  assign mode_pg1   = pg_reg[2'(OFS_PG1)];
  assign mode_pg2   = pg_reg[2'(OFS_PG2)];
  assign mode_pg3   = pg_reg[2'(OFS_PG3)];
  assign mode_norom = norom_reg;
  assign mode_ramro = ramro_reg;
  assign pg_upd     = pg_upd_reg;

`ifdef MEMMAP_READBACK_EN
  logic [7:0] rd_data;
  logic       rd_hit;
  logic [7:0] dout_reg;
  logic       dout_en_reg;

  assign rd_hit = ctrl_hit | (|pg_hit);

  always_comb begin
    rd_data = 8'h00;
    if (ctrl_hit) begin
      rd_data[CTRL_NOROM] = norom_reg;
      rd_data[CTRL_RAMRO] = ramro_reg;
    end else if (|pg_hit) begin
      rd_data = pg_reg[ofs[1:0]];
    end
  end

  // A coincident write edge takes priority; the read is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg    <= 8'h00;
      dout_en_reg <= 1'b0;
    end else if (rd_rise && !wr_rise && rd_hit) begin
      dout_reg    <= rd_data;
      dout_en_reg <= 1'b1;
    end else if (!rd_s) begin
      dout_en_reg <= 1'b0;
    end
  end

  assign dout    = dout_reg;
  assign dout_en = dout_en_reg;
`else
  logic unused_rd;
  assign unused_rd = rd_s | rd_rise;
  assign dout      = 8'h00;
  assign dout_en   = 1'b0;
`endif

endmodule

// File: tb/tb_memmap_regs.sv
// Directed bench for memmap_regs: a bus-level register model checked every cycle,
// plus literal spot checks. Readback expectations follow MEMMAP_READBACK_EN.
module tb_memmap_regs;

  localparam int         SS   = 2;
  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       rst;
  logic       iorq_n, m1_n, rd_n, wr_n;
  logic [7:0] a, din;
  logic [7:0] dout;
  logic       dout_en;
  logic [7:0] mode_pg0, mode_pg1, mode_pg2, mode_pg3;
  logic       mode_norom, mode_ramro, pg_upd;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_pg [4];
  logic       exp_norom, exp_ramro, exp_upd, exp_dout_en;
  logic [7:0] exp_dout;
  bit         chk_en = 0;

  always #5 clk = ~clk;

  memmap_regs #(.SYNC_STAGES(SS), .PORT_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .a(a), .din(din), .dout(dout), .dout_en(dout_en),
    .mode_pg0(mode_pg0), .mode_pg1(mode_pg1), .mode_pg2(mode_pg2), .mode_pg3(mode_pg3),
    .mode_norom(mode_norom), .mode_ramro(mode_ramro), .pg_upd(pg_upd)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pg[0] = 8'h00; exp_pg[1] = 8'h03; exp_pg[2] = 8'h00; exp_pg[3] = 8'h00;
    exp_norom = 1'b0; exp_ramro = 1'b0; exp_upd = 1'b0;
    exp_dout = 8'h00; exp_dout_en = 1'b0;
  endtask

  // Single compare process: outputs against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check8("mode_pg0", mode_pg0, exp_pg[0]);
      check8("mode_pg1", mode_pg1, exp_pg[1]);
      check8("mode_pg2", mode_pg2, exp_pg[2]);
      check8("mode_pg3", mode_pg3, exp_pg[3]);
      check8("mode_norom", {7'b0, mode_norom}, {7'b0, exp_norom});
      check8("mode_ramro", {7'b0, mode_ramro}, {7'b0, exp_ramro});
      check8("pg_upd", {7'b0, pg_upd}, {7'b0, exp_upd});
      check8("dout_en", {7'b0, dout_en}, {7'b0, exp_dout_en});
`ifdef MEMMAP_READBACK_EN
      if (exp_dout_en) check8("dout", dout, exp_dout);
`else
      check8("dout", dout, 8'h00);
`endif
    end
  end

  // OUT (addr),data. The register changes SS edges after the first edge that
  // sees the strobe, i.e. on the (SS+1)th posedge after it is driven.
  task automatic io_write(input logic [7:0] addr, input logic [7:0] data,
                          input logic m1_val, input int hold);
    int ofs;
    bit accept;
    @(negedge clk);
    a = addr; din = data; m1_n = m1_val; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (SS + 1) @(posedge clk);
    ofs    = int'(addr) - int'(BASE);
    accept = m1_val && (ofs >= 0) && (ofs <= 4);
    if (accept) begin
      if (ofs < 4) begin
        exp_upd    = (exp_pg[ofs] != data);
        exp_pg[ofs] = data;
      end else begin
        exp_upd   = (exp_norom != data[0]) || (exp_ramro != data[1]);
        exp_norom = data[0];
        exp_ramro = data[1];
      end
    end
    @(posedge clk);
    exp_upd = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    repeat (SS + 3) @(posedge clk);
    $display("OUT (%02h),%02h m1_n=%0b hold=%0d accepted=%0b", addr, data, m1_val, hold, accept);
  endtask

  // IN from addr; dout_en drops SS+1 edges after the strobe is removed.
  task automatic io_read(input logic [7:0] addr, input int hold);
    int ofs;
    bit hit;
    @(negedge clk);
    a = addr; m1_n = 1'b1; iorq_n = 1'b0; rd_n = 1'b0;
    repeat (SS + 1) @(posedge clk);
    ofs = int'(addr) - int'(BASE);
    hit = (ofs >= 0) && (ofs <= 4);
`ifdef MEMMAP_READBACK_EN
    if (hit) begin
      exp_dout    = (ofs < 4) ? exp_pg[ofs] : {6'b0, exp_ramro, exp_norom};
      exp_dout_en = 1'b1;
    end
`endif
    repeat (hold) @(posedge clk);
    @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1;
    repeat (SS + 1) @(posedge clk);
    exp_dout_en = 1'b0;
    repeat (2) @(posedge clk);
    $display("IN (%02h) hold=%0d decoded=%0b", addr, hold, hit);
  endtask

  initial begin
    rst = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a = 8'h00; din = 8'h00;
    model_reset();
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check8("rst_pg0", mode_pg0, 8'h00);
    check8("rst_pg1", mode_pg1, 8'h03);
    check8("rst_pg2", mode_pg2, 8'h00);
    check8("rst_pg3", mode_pg3, 8'h00);
    check8("rst_pg_upd", {7'b0, pg_upd}, 8'h00);
    check8("rst_dout_en", {7'b0, dout_en}, 8'h00);
    rst = 1'b0;
    $display("RESET released");
    repeat (4) @(posedge clk);

    io_read(8'h11, 3);
    io_write(8'h12, 8'h5A, 1'b1, 2);
    @(negedge clk);
    check8("lit_pg2", mode_pg2, 8'h5A);
    io_write(8'h12, 8'h5A, 1'b1, 2);

    io_write(8'h14, 8'hFF, 1'b1, 2);
    @(negedge clk);
    check8("lit_ctrl_ff", {6'b0, mode_ramro, mode_norom}, 8'h03);
    io_read(8'h14, 2);
    io_read(8'h20, 2);
    io_write(8'h14, 8'h00, 1'b1, 2);
    @(negedge clk);
    check8("lit_ctrl_00", {6'b0, mode_ramro, mode_norom}, 8'h00);

    io_write(8'h20, 8'h77, 1'b1, 2);
    io_write(8'h13, 8'h66, 1'b0, 2);
    io_write(8'h13, 8'h9C, 1'b1, 50);
    @(negedge clk);
    check8("lit_pg3", mode_pg3, 8'h9C);
    io_write(8'h11, 8'h0A, 1'b1, 1);

    // Reset lands one edge into a write and is released with the strobe held.
    @(negedge clk);
    a = 8'h10; din = 8'h55; m1_n = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (6) @(posedge clk);
    $display("RESET mid-strobe OUT (10),55 discarded");
    @(negedge clk);
    check8("lit_mid_pg0", mode_pg0, 8'h00);
    check8("lit_mid_pg1", mode_pg1, 8'h03);
    io_write(8'h10, 8'h07, 1'b1, 2);
    @(negedge clk);
    check8("lit_pg0", mode_pg0, 8'h07);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
